// File: rtl/vzmq_pkg.sv
// Shared types, defaults and helpers for the vzmq receive stream stage.
package vzmq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POLL,
    WAIT,
    STREAM
  } state_t;

  localparam int VZMQ_MAX_MSG      = 16384;
  localparam int VZMQ_POLL_DEFAULT = 16;

  // Valid-byte mask for a beat carrying nbytes bytes; 0 means a full beat.
  function automatic logic [63:0] keep_mask(input int unsigned nbytes,
                                            input int unsigned data_bytes);
    logic [63:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((i < data_bytes) && ((nbytes == 0) || (i < nbytes))) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/vzmq_rx_stream_beat_mux.sv
// Combinational lane selection: picks one beat of the captured message and
// builds its keep mask and last flag from the beat index and message length.
module vzmq_beat_mux
  import vzmq_pkg::*;
#(
  parameter int MAX_RCV    = VZMQ_MAX_MSG,
  parameter int DATA_BYTES = 4,
  parameter int LEN_W      = $clog2(MAX_RCV + 1),
  parameter int BEAT_W     = $clog2(MAX_RCV / DATA_BYTES + 1)
) (
  input  logic [8*MAX_RCV-1:0]    buffer,
  input  logic [BEAT_W-1:0]       beat,
  input  logic [LEN_W-1:0]        len,
  output logic [8*DATA_BYTES-1:0] data,
  output logic [DATA_BYTES-1:0]   keep,
  output logic                    last
);

  localparam int IDX_W = $clog2(8 * MAX_RCV);

  logic [31:0]             byte_off;
  logic [IDX_W-1:0]        bit_off;
  logic [8*DATA_BYTES-1:0] lanes;

  // A beat is final once its byte window reaches the end of the message.
  always_comb begin
    byte_off = 32'(beat) * 32'(DATA_BYTES);
    bit_off  = IDX_W'(byte_off * 32'd8);
    last     = (byte_off + 32'(DATA_BYTES)) >= 32'(len);
    lanes    = buffer[bit_off +: 8*DATA_BYTES];
    keep     = last ? DATA_BYTES'(keep_mask(32'(len) % 32'(DATA_BYTES), DATA_BYTES))
                    : '1;
    data     = '0;
    for (int j = 0; j < DATA_BYTES; j++) begin
      data[8*j +: 8] = keep[j] ? lanes[8*j +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/vzmq_rx_stream.sv
// Polls the vzmq DPI bridge and replays each message as an AXI-Stream burst.
// Optional VZMQ_RX_STATS_EN adds message/byte counters.
module vzmq_rx_stream
  import vzmq_pkg::*;
#(
  parameter int MAX_RCV       = VZMQ_MAX_MSG,
  parameter int DATA_BYTES    = 4,
  parameter int POLL_INTERVAL = VZMQ_POLL_DEFAULT,
  parameter int RESP_WAIT     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic                    rcv_stb,
  input  logic                    rcv_ack,
  input  logic [8*MAX_RCV-1:0]    rcv_msg,
  input  logic [31:0]             rcv_bytes,
  output logic [8*DATA_BYTES-1:0] m_tdata,
  output logic [DATA_BYTES-1:0]   m_tkeep,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    busy,
  output logic                    err_len
`ifdef VZMQ_RX_STATS_EN
  ,
  output logic [31:0]             stat_msgs,
  output logic [31:0]             stat_bytes
`endif
);

  localparam int LEN_W  = $clog2(MAX_RCV + 1);
  localparam int BEAT_W = $clog2(MAX_RCV / DATA_BYTES + 1);
  localparam int INT_W  = $clog2(POLL_INTERVAL + 1);
  localparam int WAIT_W = $clog2(RESP_WAIT + 1);

  state_t                  state;
  logic [INT_W-1:0]        interval_cnt;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [LEN_W-1:0]        len;
  logic [BEAT_W-1:0]       beat;
  logic [8*MAX_RCV-1:0]    buffer;
  logic                    valid_q;
  logic [8*DATA_BYTES-1:0] mux_data;
  logic [DATA_BYTES-1:0]   mux_keep;
  logic                    mux_last;
  logic                    handshake;

  vzmq_beat_mux #(
    .MAX_RCV    (MAX_RCV),
    .DATA_BYTES (DATA_BYTES),
    .LEN_W      (LEN_W),
    .BEAT_W     (BEAT_W)
  ) u_beat_mux (
    .buffer (buffer),
    .beat   (beat),
    .len    (len),
    .data   (mux_data),
    .keep   (mux_keep),
    .last   (mux_last)
  );

  // Data lanes are gated by the valid register so an idle port reads all zero.
  assign m_tvalid  = valid_q;
  assign m_tdata   = valid_q ? mux_data : '0;
  assign m_tkeep   = valid_q ? mux_keep : '0;
  assign m_tlast   = valid_q & mux_last;
  assign busy      = (state != IDLE);
  assign handshake = valid_q & m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      interval_cnt <= '0;
      wait_cnt     <= '0;
      len          <= '0;
      beat         <= '0;
      buffer       <= '0;
      valid_q      <= 1'b0;
      rcv_stb      <= 1'b0;
      err_len      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            if (interval_cnt == '0) begin
              state <= POLL;
            end else begin
              interval_cnt <= interval_cnt - 1'b1;
            end
          end
        end
        POLL: begin
          rcv_stb  <= ~rcv_stb;
          wait_cnt <= WAIT_W'(RESP_WAIT);
          state    <= WAIT;
        end
        // Inputs are sampled RESP_WAIT cycles after the strobe edge.
        WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt <= WAIT_W'(1)) begin
            if (!rcv_ack || ($signed(rcv_bytes) <= 0)) begin
              interval_cnt <= INT_W'(POLL_INTERVAL);
              state        <= IDLE;
            end else begin
              buffer  <= rcv_msg;
              beat    <= '0;
              valid_q <= 1'b1;
              state   <= STREAM;
              if (rcv_bytes > 32'(MAX_RCV)) begin
                len     <= LEN_W'(MAX_RCV);
                err_len <= 1'b1;
              end else begin
                len <= rcv_bytes[LEN_W-1:0];
              end
            end
          end
        end
        STREAM: begin
          if (handshake) begin
            if (mux_last) begin
              valid_q      <= 1'b0;
              interval_cnt <= '0;
              state        <= IDLE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VZMQ_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_msgs  <= '0;
      stat_bytes <= '0;
    end else if (handshake && mux_last) begin
      stat_msgs  <= stat_msgs + 32'd1;
      stat_bytes <= stat_bytes + 32'(len);
    end
  end
`endif

endmodule

// File: tb/tb_vzmq_rx_stream.sv
// Directed self-checking bench for vzmq_rx_stream; the bench plays the bridge.
module tb_vzmq_rx_stream;

  localparam int MAX_RCV       = 64;
  localparam int DATA_BYTES    = 4;
  localparam int POLL_INTERVAL = 16;
  localparam int RESP_WAIT     = 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    en = 1'b0;
  logic                    rcv_stb;
  logic                    rcv_ack = 1'b0;
  logic [8*MAX_RCV-1:0]    rcv_msg = '0;
  logic [31:0]             rcv_bytes = '0;
  logic [8*DATA_BYTES-1:0] m_tdata;
  logic [DATA_BYTES-1:0]   m_tkeep;
  logic                    m_tvalid;
  logic                    m_tready = 1'b0;
  logic                    m_tlast;
  logic                    busy;
  logic                    err_len;
`ifdef VZMQ_RX_STATS_EN
  logic [31:0]             stat_msgs;
  logic [31:0]             stat_bytes;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] beat_data [32];
  logic [3:0]  beat_keep [32];
  logic        beat_last [32];

  vzmq_rx_stream #(
    .MAX_RCV       (MAX_RCV),
    .DATA_BYTES    (DATA_BYTES),
    .POLL_INTERVAL (POLL_INTERVAL),
    .RESP_WAIT     (RESP_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rcv_stb   (rcv_stb),
    .rcv_ack   (rcv_ack),
    .rcv_msg   (rcv_msg),
    .rcv_bytes (rcv_bytes),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .busy      (busy),
    .err_len   (err_len)
`ifdef VZMQ_RX_STATS_EN
    ,
    .stat_msgs  (stat_msgs),
    .stat_bytes (stat_bytes)
`endif
  );

  always #5 clk = ~clk;

  // Bridge side: wait for the next strobe edge, present one response for the
  // sampling cycle, then fall back to "no message".
  task automatic serve(input logic ack, input logic [31:0] nbytes,
                       input int nfill, input int base, output int delay);
    logic                 prev;
    logic [8*MAX_RCV-1:0] msg;
    prev  = rcv_stb;
    delay = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (rcv_stb !== prev) begin
        delay = i;
        break;
      end
    end
    if (delay == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL poll_timeout: rcv_stb did not toggle within 200 cycles");
    end
    msg = '0;
    for (int k = MAX_RCV - 1; k >= 0; k--) begin
      msg = {msg[8*MAX_RCV-9:0], (k < nfill) ? 8'(base + k) : 8'h00};
    end
    rcv_msg   = msg;
    rcv_ack   = ack;
    rcv_bytes = nbytes;
    @(negedge clk);
    rcv_ack   = 1'b0;
    rcv_bytes = '0;
  endtask

  // Records every handshaked beat until tlast or a cycle budget expires.
  task automatic collect(output int nb);
    bit done;
    nb   = 0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (m_tvalid && m_tready) begin
        if (nb < 32) begin
          beat_data[nb] = m_tdata;
          beat_keep[nb] = m_tkeep;
          beat_last[nb] = m_tlast;
        end
        nb++;
        if (m_tlast) done = 1'b1;
      end
      if (!done) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rcv_stb !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rcv_stb: got %b expected 0", rcv_stb); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tvalid: got %b expected 0", m_tvalid); end
    n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tlast: got %b expected 0", m_tlast); end
    n_checks++; if (m_tdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_tdata: got %h expected 0", m_tdata); end
    n_checks++; if (m_tkeep !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_tkeep: got %h expected 0", m_tkeep); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (err_len !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err_len: got %b expected 0", err_len); end
`ifdef VZMQ_RX_STATS_EN
    n_checks++; if (stat_msgs !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_stat_msgs: got %0d expected 0", stat_msgs); end
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({rcv_stb, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL disabled_idle: got stb/busy %b expected 00", {rcv_stb, busy}); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_d [3] = '{32'h04030201, 32'h08070605, 32'h00000A09};
    logic [3:0]  exp_k [3] = '{4'hF, 4'hF, 4'h3};
    logic        exp_l [3] = '{1'b0, 1'b0, 1'b1};
    int          d;
    int          nb;
    logic        prev;
    m_tready = 1'b1;
    en       = 1'b1;
    serve(1'b1, 32'd10, 10, 8'h01, d);
    n_checks++; if (d !== 2) begin n_fail++; $display("[TB] FAIL first_poll_latency: got %0d expected 2", d); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_busy: got %b expected 1", busy); end
    collect(nb);
    n_checks++; if (nb !== 3) begin n_fail++; $display("[TB] FAIL basic_beats: got %0d expected 3", nb); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({beat_data[i], beat_keep[i], beat_last[i]} !== {exp_d[i], exp_k[i], exp_l[i]}) begin
        n_fail++;
        $display("[TB] FAIL basic_beat%0d: got %h/%h/%b expected %h/%h/%b", i,
                 beat_data[i], beat_keep[i], beat_last[i], exp_d[i], exp_k[i], exp_l[i]);
      end
    end
    @(negedge clk);
    n_checks++; if ({m_tvalid, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL after_last: got valid/busy %b expected 00", {m_tvalid, busy}); end
    prev = rcv_stb;
    d    = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rcv_stb !== prev) begin d = i; break; end
    end
    n_checks++; if (d !== 2) begin n_fail++; $display("[TB] FAIL back_to_back_poll: got %0d expected 2", d); end
  endtask

  task automatic test_empty_poll();
    int   d;
    int   toggles;
    logic prev;
    logic seen_valid;
    for (int pass = 0; pass < 2; pass++) begin
      rcv_ack   = (pass == 0);
      rcv_bytes = (pass == 0) ? 32'hFFFF_FFFF : 32'd7;
      prev       = rcv_stb;
      seen_valid = 1'b0;
      d          = 0;
      for (int i = 1; i <= 60; i++) begin
        @(negedge clk);
        if (m_tvalid) seen_valid = 1'b1;
        if (rcv_stb !== prev) begin d = i; break; end
      end
      n_checks++; if (d !== 19) begin n_fail++; $display("[TB] FAIL poll_period%0d: got %0d expected 19", pass, d); end
      n_checks++; if (seen_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL empty_no_valid%0d: got %b expected 0", pass, seen_valid); end
    end
    en      = 1'b0;
    rcv_ack = 1'b0;
    rcv_bytes = '0;
    prev    = rcv_stb;
    toggles = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rcv_stb !== prev) begin toggles++; prev = rcv_stb; end
    end
    n_checks++; if (toggles !== 0) begin n_fail++; $display("[TB] FAIL disabled_toggles: got %0d expected 0", toggles); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL disabled_busy: got %b expected 0", busy); end
    en = 1'b1;
    d  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rcv_stb !== prev) begin d = i; break; end
    end
    n_checks++; if (d !== 18) begin n_fail++; $display("[TB] FAIL frozen_interval: got %0d expected 18", d); end
  endtask

  task automatic test_backpressure();
    int d;
    serve(1'b1, 32'd8, 8, 8'h11, d);
    n_checks++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast} !== {1'b1, 32'h14131211, 4'hF, 1'b0}) begin
      n_fail++; $display("[TB] FAIL bp_beat0: got %b/%h/%h/%b expected 1/14131211/f/0", m_tvalid, m_tdata, m_tkeep, m_tlast);
    end
    @(negedge clk);
    m_tready = 1'b0;
    n_checks++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast} !== {1'b1, 32'h18171615, 4'hF, 1'b1}) begin
      n_fail++; $display("[TB] FAIL bp_beat1: got %b/%h/%h/%b expected 1/18171615/f/1", m_tvalid, m_tdata, m_tkeep, m_tlast);
    end
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      n_checks++;
      if ({m_tvalid, m_tdata, m_tkeep, m_tlast} !== {1'b1, 32'h18171615, 4'hF, 1'b1}) begin
        n_fail++; $display("[TB] FAIL bp_hold_c%0d: got %b/%h/%h/%b expected 1/18171615/f/1", c, m_tvalid, m_tdata, m_tkeep, m_tlast);
      end
    end
    m_tready = 1'b1;
    @(negedge clk);
    n_checks++; if ({m_tvalid, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL bp_done: got valid/busy %b expected 00", {m_tvalid, busy}); end
  endtask

  task automatic test_oversize();
    int          d;
    int          nb;
    logic [31:0] e;
    serve(1'b1, 32'(MAX_RCV + 5), MAX_RCV, 0, d);
    collect(nb);
    n_checks++; if (nb !== MAX_RCV / DATA_BYTES) begin n_fail++; $display("[TB] FAIL oversize_beats: got %0d expected %0d", nb, MAX_RCV / DATA_BYTES); end
    for (int i = 0; i < MAX_RCV / DATA_BYTES; i++) begin
      e = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      n_checks++;
      if ({beat_data[i], beat_keep[i], beat_last[i]} !== {e, 4'hF, (i == MAX_RCV / DATA_BYTES - 1)}) begin
        n_fail++; $display("[TB] FAIL oversize_beat%0d: got %h/%h/%b expected %h/f/%b", i,
                           beat_data[i], beat_keep[i], beat_last[i], e, (i == MAX_RCV / DATA_BYTES - 1));
      end
    end
    n_checks++; if (err_len !== 1'b1) begin n_fail++; $display("[TB] FAIL oversize_err_len: got %b expected 1", err_len); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] exp_d [3] = '{32'h44434241, 32'h48474645, 32'h4C4B4A49};
    int          d;
    int          nb;
    serve(1'b1, 32'd12, 12, 8'h21, d);
    n_checks++; if (err_len !== 1'b1) begin n_fail++; $display("[TB] FAIL err_len_sticky: got %b expected 1", err_len); end
    n_checks++; if (m_tdata !== 32'h24232221) begin n_fail++; $display("[TB] FAIL mid_beat0: got %h expected 24232221", m_tdata); end
    @(negedge clk);
    n_checks++; if (m_tdata !== 32'h28272625) begin n_fail++; $display("[TB] FAIL mid_beat1: got %h expected 28272625", m_tdata); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_tvalid, m_tlast, busy, rcv_stb, err_len, m_tkeep} !== 9'b0) begin
      n_fail++; $display("[TB] FAIL async_reset: got valid/last/busy/stb/err/keep %b%b%b%b%b/%h expected all 0",
                         m_tvalid, m_tlast, busy, rcv_stb, err_len, m_tkeep);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    serve(1'b1, 32'd12, 12, 8'h41, d);
    collect(nb);
    n_checks++; if (nb !== 3) begin n_fail++; $display("[TB] FAIL post_reset_beats: got %0d expected 3", nb); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({beat_data[i], beat_keep[i], beat_last[i]} !== {exp_d[i], 4'hF, (i == 2)}) begin
        n_fail++; $display("[TB] FAIL post_reset_beat%0d: got %h/%h/%b expected %h/f/%b", i,
                           beat_data[i], beat_keep[i], beat_last[i], exp_d[i], (i == 2));
      end
    end
  endtask

  task automatic test_stats();
    int d;
    int nb;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    serve(1'b1, 32'd10, 10, 8'h51, d);
    collect(nb);
    n_checks++;
    if ({nb[7:0], beat_data[2], beat_keep[2], beat_last[2]} !== {8'd3, 32'h00005A59, 4'h3, 1'b1}) begin
      n_fail++; $display("[TB] FAIL stats_msg10: got %0d beats last %h/%h/%b expected 3 beats 00005a59/3/1",
                         nb, beat_data[2], beat_keep[2], beat_last[2]);
    end
    serve(1'b1, 32'd3, 3, 8'h61, d);
    collect(nb);
    n_checks++;
    if ({nb[7:0], beat_data[0], beat_keep[0], beat_last[0]} !== {8'd1, 32'h00636261, 4'h7, 1'b1}) begin
      n_fail++; $display("[TB] FAIL single_beat_msg3: got %0d beats %h/%h/%b expected 1 beat 00636261/7/1",
                         nb, beat_data[0], beat_keep[0], beat_last[0]);
    end
    @(negedge clk);
`ifdef VZMQ_RX_STATS_EN
    n_checks++; if (stat_msgs !== 32'd2) begin n_fail++; $display("[TB] FAIL stat_msgs: got %0d expected 2", stat_msgs); end
    n_checks++; if (stat_bytes !== 32'd13) begin n_fail++; $display("[TB] FAIL stat_bytes: got %0d expected 13", stat_bytes); end
`endif
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] vzmq_rx_stream bench start");
    test_reset();
    test_basic();
    test_empty_poll();
    test_backpressure();
    test_oversize();
    test_reset_midstream();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
